// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - frame header constant and loader state encodings
package program_loader_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, instruction-memory write port out
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// rtl/program_loader_byte_assembler.sv - packs 4 bytes MSB-first into a word, pulses on completion
module program_loader_byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0]  cnt;
    logic [23:0] shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 2'd0;
            shift      <= 24'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                cnt <= 2'd0;
            end else if (byte_valid) begin
                shift <= {shift[15:0], byte_data};
                cnt   <= cnt + 2'd1;
                // word and strobe land together, one cycle after the 4th byte
                if (cnt == 2'd3) begin
                    word       <= {shift, byte_data};
                    word_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - receives a framed program and writes it into instruction memory
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    program_loader_if.slave     bus,
    output logic                cpu_rst,
    output logic                done,
    output logic                error,
    output logic [7:0]          word_count
);
    logic [2:0]            state;
    logic [7:0]            len;
    logic [9:0]            byte_cnt;
    logic [7:0]            chk;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  accept;
    logic                  idle_like;
    logic                  last_byte;
    logic                  word_done;
    logic [31:0]           word;

    assign accept    = bus.in_valid && bus.in_ready;
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    assign last_byte = (byte_cnt == ({len, 2'b00} - 10'd1));

    program_loader_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start && idle_like),
        .byte_valid (accept && (state == ST_DATA)),
        .byte_data  (bus.in_data),
        .word       (word),
        .word_valid (word_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            len        <= 8'd0;
            byte_cnt   <= 10'd0;
            chk        <= 8'd0;
            addr       <= '0;
            word_count <= 8'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_HDR;
                        byte_cnt <= 10'd0;
                        chk      <= 8'd0;
                        addr     <= '0;
                    end
                end
                ST_HDR: begin
                    // anything other than the header byte is dropped to resynchronise
                    if (accept && bus.in_data == HDR_BYTE)
                        state <= ST_LEN;
                end
                ST_LEN: begin
                    if (accept) begin
                        len <= bus.in_data;
                        if (bus.in_data == 8'd0 || 32'(bus.in_data) > MAX_WORDS) begin
                            state      <= ST_ERR;
                            word_count <= 8'd0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 10'd1;
                        chk      <= chk ^ bus.in_data;
                        if (last_byte)
                            state <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        word_count <= len;
                        state      <= (bus.in_data == chk) ? ST_DONE : ST_ERR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (word_done)
                addr <= addr + 1'b1;
        end
    end

    assign bus.in_ready  = (state == ST_HDR) || (state == ST_LEN) ||
                           (state == ST_DATA) || (state == ST_CHK);
    assign bus.mem_we    = word_done;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = word;
    assign cpu_rst       = (state != ST_DONE);
    assign done          = (state == ST_DONE);
    assign error         = (state == ST_ERR);
endmodule
